// File: rtl/vector_seq_pkg.sv
// Shared types and defaults for the vector instruction sequencer.
package vector_seq_pkg;

    localparam int unsigned DEFAULT_VLEN  = 8;
    localparam int unsigned DEFAULT_LANES = 2;

    typedef enum logic [1:0] {
        OP_ALU   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10
    } vseq_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEMWAIT,
        DONE
    } vseq_state_t;

    // Map the raw 2-bit opcode; the reserved encoding behaves as an ALU op.
    function automatic vseq_op_t decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_op = OP_LOAD;
            2'b10:   decode_op = OP_STORE;
            default: decode_op = OP_ALU;
        endcase
    endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Beat decode: first element index, active-lane mask and last-beat flag.
module lane_mask_gen
    import vector_seq_pkg::*;
#(
    parameter int unsigned VLEN  = DEFAULT_VLEN,
    parameter int unsigned LANES = DEFAULT_LANES,
    parameter int unsigned IDXW  = $clog2(VLEN),
    parameter int unsigned VLW   = $clog2(VLEN + 1),
    parameter int unsigned BW    = 2
) (
    input  logic [BW-1:0]    beat,
    input  logic [VLW-1:0]   vl_eff,
    output logic [IDXW-1:0]  elem_base,
    output logic [LANES-1:0] lane_mask,
    output logic             last_beat
);

    // VLW bits are wide enough for base + LANES, which never exceeds VLEN.
    logic [VLW-1:0] base_v;

    assign base_v = VLW'(beat) * VLW'(LANES);

    // Per-lane activity and last-beat detection against the latched length.
    always_comb begin
        elem_base = IDXW'(base_v);
        lane_mask = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_mask[i] = (base_v + VLW'(i)) < vl_eff;
        end
        last_beat = (base_v + VLW'(LANES)) >= vl_eff;
    end

endmodule

// File: rtl/vector_sequencer.sv
// Multi-cycle vector instruction sequencer: splits an instruction into
// LANES-wide beats and drives register-write / memory-request controls.
module vector_sequencer
    import vector_seq_pkg::*;
#(
    parameter int unsigned VLEN  = DEFAULT_VLEN,
    parameter int unsigned LANES = DEFAULT_LANES,
    parameter int unsigned IDXW  = $clog2(VLEN),
    parameter int unsigned VLW   = $clog2(VLEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cond_ex,
    input  logic [1:0]       op,
    input  logic [VLW-1:0]   vl,
    input  logic             mem_ack,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [IDXW-1:0]  elem_base,
    output logic [LANES-1:0] lane_mask,
    output logic             vreg_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             done
);

    localparam int unsigned NBEATS = VLEN / LANES;
    localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    vseq_state_t    state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    vseq_op_t       op_q, op_d;
    logic [VLW-1:0] vl_q, vl_d;

    logic           accept;
    logic [VLW-1:0] vl_clamped;
    logic [IDXW-1:0]  base_raw;
    logic [LANES-1:0] mask_raw;
    logic           last_beat;
    logic           active;

    assign vl_clamped = (vl > VLW'(VLEN)) ? VLW'(VLEN) : vl;
    assign accept     = (state_q == IDLE) && start && cond_ex && !flush;
    assign active     = (state_q == EXEC) || (state_q == MEMWAIT);

    lane_mask_gen #(
        .VLEN  (VLEN),
        .LANES (LANES),
        .IDXW  (IDXW),
        .VLW   (VLW),
        .BW    (BW)
    ) u_lane_mask_gen (
        .beat      (beat_q),
        .vl_eff    (vl_q),
        .elem_base (base_raw),
        .lane_mask (mask_raw),
        .last_beat (last_beat)
    );

    // State, beat counter and latched instruction fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            op_q    <= OP_ALU;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            op_q    <= op_d;
            vl_q    <= vl_d;
        end
    end

    // Next-state: accept, beat advance, flush abort.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        op_d    = op_q;
        vl_d    = vl_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = decode_op(op);
                    vl_d   = vl_clamped;
                    beat_d = '0;
                    if (vl_clamped == '0) begin
                        state_d = DONE;
                    end else if (decode_op(op) == OP_ALU) begin
                        state_d = EXEC;
                    end else begin
                        state_d = MEMWAIT;
                    end
                end
            end
            EXEC: begin
                if (flush) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (last_beat) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            MEMWAIT: begin
                if (flush) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (mem_ack) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Output decode; only stall looks at the incoming instruction.
    always_comb begin
        busy      = (state_q != IDLE);
        stall     = (busy && (state_q != DONE)) || accept;
        elem_base = active ? base_raw : '0;
        lane_mask = active ? mask_raw : '0;
        mem_req   = (state_q == MEMWAIT) && !flush;
        mem_we    = mem_req && (op_q == OP_STORE);
        vreg_we   = ((state_q == EXEC) && !flush) ||
                    (mem_req && (op_q == OP_LOAD) && mem_ack);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: stimulus queues expected beat
// events, a negedge monitor pops and compares them.
module tb_vector_sequencer;
    import vector_seq_pkg::*;

    localparam int unsigned VLEN  = 8;
    localparam int unsigned LANES = 2;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned VLW   = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             cond_ex;
    logic [1:0]       op;
    logic [VLW-1:0]   vl;
    logic             mem_ack;
    logic             flush;
    logic             stall;
    logic             busy;
    logic [IDXW-1:0]  elem_base;
    logic [LANES-1:0] lane_mask;
    logic             vreg_we;
    logic             mem_req;
    logic             mem_we;
    logic             done;

    vector_sequencer #(
        .VLEN  (VLEN),
        .LANES (LANES),
        .IDXW  (IDXW),
        .VLW   (VLW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cond_ex   (cond_ex),
        .op        (op),
        .vl        (vl),
        .mem_ack   (mem_ack),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .elem_base (elem_base),
        .lane_mask (lane_mask),
        .vreg_we   (vreg_we),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       done;
        logic [2:0] eb;
        logic [1:0] mask;
        logic       we;
        logic       mreq;
        logic       mwe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests;
    int   fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_beat(input logic [2:0] eb, input logic [1:0] mask,
                             input logic we, input logic mreq, input logic mwe);
        exp_q.push_back('{done: 1'b0, eb: eb, mask: mask, we: we, mreq: mreq, mwe: mwe});
    endtask

    task automatic push_done();
        exp_q.push_back('{done: 1'b1, eb: 3'd0, mask: 2'b00, we: 1'b0, mreq: 1'b0, mwe: 1'b0});
    endtask

    // Monitor: a beat retires on vreg_we, on an acked request, or on done.
    always @(negedge clk) begin
        if (rst) begin
            if (done || vreg_we || (mem_req && mem_ack)) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: eb=%0d mask=%b we=%b req=%b done=%b",
                             elem_base, lane_mask, vreg_we, mem_req, done);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mon_done", 32'(done), 32'(mon_e.done));
                    check("mon_elem_base", 32'(elem_base), 32'(mon_e.eb));
                    check("mon_lane_mask", 32'(lane_mask), 32'(mon_e.mask));
                    check("mon_vreg_we", 32'(vreg_we), 32'(mon_e.we));
                    check("mon_mem_req", 32'(mem_req), 32'(mon_e.mreq));
                    check("mon_mem_we", 32'(mem_we), 32'(mon_e.mwe));
                end
            end else if (mem_req) begin
                // Request waiting for ack: controls must match the pending beat.
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_mem_req: eb=%0d", elem_base);
                end else begin
                    mon_e = exp_q[0];
                    check("hold_elem_base", 32'(elem_base), 32'(mon_e.eb));
                    check("hold_lane_mask", 32'(lane_mask), 32'(mon_e.mask));
                    check("hold_mem_we", 32'(mem_we), 32'(mon_e.mwe));
                    check("hold_vreg_we", 32'(vreg_we), 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [3:0] l, input string tag);
        @(posedge clk);
        #1;
        start   = 1'b1;
        cond_ex = 1'b1;
        op      = o;
        vl      = l;
        @(negedge clk);
        check({tag, "_accept_stall"}, 32'(stall), 32'd1);
        check({tag, "_accept_busy"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start   = 1'b0;
        cond_ex = 1'b0;
        op      = 2'b00;
        vl      = '0;
    endtask

    // Cycle-exact stall/done timing after an ALU accept.
    task automatic alu_timing(input int nbeats, input string tag);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            check({tag, "_beat_stall"}, 32'(stall), 32'd1);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
    endtask

    // Ack each request two cycles after it appears.
    task automatic mem_acks(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            int c;
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!mem_req && c < 20);
            check({tag, "_req_seen"}, 32'(mem_req), 32'd1);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            mem_ack = 1'b1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < 50);
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_elem_base"}, 32'(elem_base), 32'd0);
        check({tag, "_lane_mask"}, 32'(lane_mask), 32'd0);
        check({tag, "_vreg_we"}, 32'(vreg_we), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b0;
        start   = 1'b0;
        cond_ex = 1'b0;
        op      = 2'b00;
        vl      = '0;
        mem_ack = 1'b0;
        flush   = 1'b0;

        #12;
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ALU vl=8: four full beats.
        push_beat(3'd0, 2'b11, 1, 0, 0);
        push_beat(3'd2, 2'b11, 1, 0, 0);
        push_beat(3'd4, 2'b11, 1, 0, 0);
        push_beat(3'd6, 2'b11, 1, 0, 0);
        push_done();
        issue(2'b00, 4'd8, "alu8");
        alu_timing(4, "alu8");

        // ALU vl=5: partial last beat.
        push_beat(3'd0, 2'b11, 1, 0, 0);
        push_beat(3'd2, 2'b11, 1, 0, 0);
        push_beat(3'd4, 2'b01, 1, 0, 0);
        push_done();
        issue(2'b00, 4'd5, "alu5");
        alu_timing(3, "alu5");

        // ALU vl=12 clamps to 8.
        push_beat(3'd0, 2'b11, 1, 0, 0);
        push_beat(3'd2, 2'b11, 1, 0, 0);
        push_beat(3'd4, 2'b11, 1, 0, 0);
        push_beat(3'd6, 2'b11, 1, 0, 0);
        push_done();
        issue(2'b00, 4'd12, "alu12");
        alu_timing(4, "alu12");

        // Reserved opcode behaves as ALU; vl=1 gives one half beat.
        push_beat(3'd0, 2'b01, 1, 0, 0);
        push_done();
        issue(2'b11, 4'd1, "rsvd");
        alu_timing(1, "rsvd");

        // STORE vl=4.
        push_beat(3'd0, 2'b11, 0, 1, 1);
        push_beat(3'd2, 2'b11, 0, 1, 1);
        push_done();
        issue(2'b10, 4'd4, "store4");
        mem_acks(2, "store4");
        wait_idle("store4");

        // LOAD vl=4: write only in ack cycles.
        push_beat(3'd0, 2'b11, 1, 1, 0);
        push_beat(3'd2, 2'b11, 1, 1, 0);
        push_done();
        issue(2'b01, 4'd4, "load4");
        mem_acks(2, "load4");
        wait_idle("load4");

        // Condition failed, plus a stray ack: nothing happens.
        @(posedge clk);
        #1;
        start   = 1'b1;
        cond_ex = 1'b0;
        vl      = 4'd8;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("condfail");
        end
        @(posedge clk);
        #1;
        // Flush in IDLE blocks acceptance.
        cond_ex = 1'b1;
        flush   = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_quiet("idleflush");
        @(posedge clk);
        #1;
        start   = 1'b0;
        cond_ex = 1'b0;
        flush   = 1'b0;
        vl      = '0;
        @(negedge clk);
        check_quiet("idleflush_after");

        // vl=0: stall only in accept cycle, done next cycle.
        push_done();
        issue(2'b00, 4'd0, "vl0");
        @(negedge clk);
        check("vl0_done", 32'(done), 32'd1);
        check("vl0_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("vl0_idle", 32'(busy), 32'd0);

        // Flush during beat 1 of ALU vl=8.
        push_beat(3'd0, 2'b11, 1, 0, 0);
        issue(2'b00, 4'd8, "flush");
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_vreg_we", 32'(vreg_we), 32'd0);
        check("flush_elem_base", 32'(elem_base), 32'd2);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", 32'(busy), 32'd0);
        check("flush_no_done", 32'(done), 32'd0);
        push_beat(3'd0, 2'b11, 1, 0, 0);
        push_done();
        issue(2'b00, 4'd2, "postflush");
        alu_timing(1, "postflush");

        // Asynchronous reset during beat 2 of ALU vl=8.
        push_beat(3'd0, 2'b11, 1, 0, 0);
        push_beat(3'd2, 2'b11, 1, 0, 0);
        issue(2'b00, 4'd8, "rstmid");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rstmid_pre_base", 32'(elem_base), 32'd4);
        #1;
        rst = 1'b0;
        #1;
        check_quiet("rstmid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rstmid_after");

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
